// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN layer stages.
// FSM encodings, output-size math and the int8 floor value.
package cnn_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_ADDR    = 4'd2,
    S_CAPTURE = 4'd3,
    S_STORE   = 4'd4,
    S_ADV     = 4'd5,
    S_DONE    = 4'd6
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;

  localparam logic signed [DEF_DATA_WIDTH-1:0] MIN_VAL =
    {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  function automatic int out_dim(
    input int in,
    input int k,
    input int stride,
    input int pad
  );
    return (in + 2*pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/max_relu_unit.sv
// Signed two-operand max plus an optional clamp-to-zero.
// Ties keep operand a, so the running max is never replaced by an equal.
module max_relu_unit #(
  parameter int DATA_WIDTH = 8,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] max_ab,
  output logic signed [DATA_WIDTH-1:0] relu_a
);

  always_comb begin
    max_ab = (b > a) ? b : a;
    relu_a = a;
    if (RELU_EN && a[DATA_WIDTH-1])
      relu_a = '0;
  end

endmodule

// File: rtl/relu_maxpool2d.sv
// 2-D max pooling with optional ReLU over a CHW int8 map.
// One window element per ADDR/CAPTURE pair; one write per window.
module relu_maxpool2d
  import cnn_pkg::*;
#(
  parameter int CHANNELS   = 64,
  parameter int IN_HEIGHT  = 2,
  parameter int IN_WIDTH   = 2,
  parameter int POOL_SIZE  = 2,
  parameter int STRIDE     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] input_addr,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_en,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  localparam int OUT_H = out_dim(IN_HEIGHT, POOL_SIZE, STRIDE, 0);
  localparam int OUT_W = out_dim(IN_WIDTH, POOL_SIZE, STRIDE, 0);

  localparam logic [15:0] K_LAST  = 16'(POOL_SIZE - 1);
  localparam logic [15:0] OH_LAST = 16'(OUT_H - 1);
  localparam logic [15:0] OW_LAST = 16'(OUT_W - 1);
  localparam logic [15:0] CH_LAST = 16'(CHANNELS - 1);

  localparam logic signed [DATA_WIDTH-1:0] MIN_V =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, next;

  logic [15:0] ch, orow, ocol, kr, kc;
  logic [15:0] kr_n, kc_n;
  logic        last_k, last_px;
  logic [31:0] rd_lin, rd_lin_n, wr_lin;

  logic signed [DATA_WIDTH-1:0] max_r;
  logic signed [DATA_WIDTH-1:0] max_new;
  logic signed [DATA_WIDTH-1:0] relu_max;

  function automatic logic [31:0] rd_addr(
    input logic [15:0] c,
    input logic [15:0] r,
    input logic [15:0] q,
    input logic [15:0] a,
    input logic [15:0] b
  );
    return 32'(c) * 32'(IN_HEIGHT * IN_WIDTH)
         + (32'(r) * 32'(STRIDE) + 32'(a)) * 32'(IN_WIDTH)
         + 32'(q) * 32'(STRIDE) + 32'(b);
  endfunction

  max_relu_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .RELU_EN   (RELU_EN)
  ) u_max_relu (
    .a     (max_r),
    .b     (input_data),
    .max_ab(max_new),
    .relu_a(relu_max)
  );

  always_comb begin
    last_k  = (kr == K_LAST) && (kc == K_LAST);
    last_px = (ocol == OW_LAST) && (orow == OH_LAST)
           && (ch == CH_LAST);
    kc_n = kc + 16'd1;
    kr_n = kr;
    if (kc == K_LAST) begin
      kc_n = '0;
      kr_n = kr + 16'd1;
    end
    rd_lin   = rd_addr(ch, orow, ocol, kr, kc);
    rd_lin_n = rd_addr(ch, orow, ocol, kr_n, kc_n);
    wr_lin   = 32'(ch) * 32'(OUT_H * OUT_W)
             + 32'(orow) * 32'(OUT_W) + 32'(ocol);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    if (start) next = S_INIT;
      S_INIT:    next = S_ADDR;
      S_ADDR:    next = S_CAPTURE;
      S_CAPTURE: next = last_k ? S_STORE : S_ADDR;
      S_STORE:   next = S_ADV;
      S_ADV:     next = last_px ? S_DONE : S_INIT;
      S_DONE:    if (!start) next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  // Read strobe is raised on entry to ADDR so the memory sees it there.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      valid       <= 1'b0;
      input_en    <= 1'b0;
      input_addr  <= '0;
      output_en   <= 1'b0;
      output_we   <= 1'b0;
      output_addr <= '0;
      output_data <= '0;
      max_r       <= '0;
      ch          <= '0;
      orow        <= '0;
      ocol        <= '0;
      kr          <= '0;
      kc          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done      <= 1'b0;
          valid     <= 1'b0;
          input_en  <= 1'b0;
          output_en <= 1'b0;
          output_we <= 1'b0;
          if (start) begin
            ch   <= '0;
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
          end
        end
        S_INIT: begin
          max_r      <= MIN_V;
          input_addr <= rd_lin[ADDR_WIDTH-1:0];
          input_en   <= 1'b1;
        end
        S_ADDR: begin
          input_en <= 1'b0;
        end
        S_CAPTURE: begin
          max_r <= max_new;
          if (last_k) begin
            kr <= '0;
            kc <= '0;
          end else begin
            kr         <= kr_n;
            kc         <= kc_n;
            input_addr <= rd_lin_n[ADDR_WIDTH-1:0];
            input_en   <= 1'b1;
          end
        end
        S_STORE: begin
          output_data <= relu_max;
          output_addr <= wr_lin[ADDR_WIDTH-1:0];
          output_en   <= 1'b1;
          output_we   <= 1'b1;
        end
        S_ADV: begin
          output_en <= 1'b0;
          output_we <= 1'b0;
          if (ocol != OW_LAST) begin
            ocol <= ocol + 16'd1;
          end else begin
            ocol <= '0;
            if (orow != OH_LAST) begin
              orow <= orow + 16'd1;
            end else begin
              orow <= '0;
              ch   <= ch + 16'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          valid <= 1'b1;
        end
        default: begin
          input_en  <= 1'b0;
          output_en <= 1'b0;
          output_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Scoreboard bench for relu_maxpool2d: three instances, directed maps.
// Writes are matched against queued expectations by monitors.
module tb_relu_maxpool2d;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t q_c[$];

  int errors = 0;
  int checks = 0;
  int a_reads = 0;
  int b_reads = 0;

  logic start_a = 1'b0;
  logic start_bc = 1'b0;

  logic       a_done, a_valid, a_ien, a_oen, a_we;
  logic [7:0] a_iaddr, a_oaddr, a_idata, a_odata;
  logic       b_done, b_valid, b_ien, b_oen, b_we;
  logic [7:0] b_iaddr, b_oaddr, b_idata, b_odata;
  logic       c_done, c_valid, c_ien, c_oen, c_we;
  logic [7:0] c_iaddr, c_oaddr, c_idata, c_odata;

  logic [7:0] mem_a [256];
  logic [7:0] mem_bc [256];

  relu_maxpool2d #(
    .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
    .POOL_SIZE(2), .STRIDE(2), .DATA_WIDTH(8),
    .ADDR_WIDTH(8), .RELU_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .done(a_done), .valid(a_valid),
    .input_addr(a_iaddr), .input_data(a_idata),
    .input_en(a_ien), .output_addr(a_oaddr),
    .output_data(a_odata), .output_we(a_we),
    .output_en(a_oen)
  );

  relu_maxpool2d #(
    .CHANNELS(2), .IN_HEIGHT(5), .IN_WIDTH(5),
    .POOL_SIZE(2), .STRIDE(2), .DATA_WIDTH(8),
    .ADDR_WIDTH(8), .RELU_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_bc),
    .done(b_done), .valid(b_valid),
    .input_addr(b_iaddr), .input_data(b_idata),
    .input_en(b_ien), .output_addr(b_oaddr),
    .output_data(b_odata), .output_we(b_we),
    .output_en(b_oen)
  );

  relu_maxpool2d #(
    .CHANNELS(2), .IN_HEIGHT(5), .IN_WIDTH(5),
    .POOL_SIZE(2), .STRIDE(2), .DATA_WIDTH(8),
    .ADDR_WIDTH(8), .RELU_EN(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .start(start_bc),
    .done(c_done), .valid(c_valid),
    .input_addr(c_iaddr), .input_data(c_idata),
    .input_en(c_ien), .output_addr(c_oaddr),
    .output_data(c_odata), .output_we(c_we),
    .output_en(c_oen)
  );

  always @(posedge clk) begin
    if (a_ien) a_idata <= mem_a[a_iaddr];
    if (b_ien) b_idata <= mem_bc[b_iaddr];
    if (c_ien) c_idata <= mem_bc[c_iaddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input int a, input int d);
    wr_t w;
    w.a = 8'(a);
    w.d = 8'(d);
    return w;
  endfunction

  task automatic sb_pop(
    input string name,
    inout wr_t q[$],
    input logic [7:0] addr,
    input logic [7:0] data,
    input logic en
  );
    wr_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got write a=%0d d=%0d want none",
               name, addr, data);
    end else begin
      e = q.pop_front();
      chk({name, "_waddr"}, int'(addr), int'(e.a));
      chk({name, "_wdata"}, int'(data), int'(e.d));
    end
    chk({name, "_wen"}, int'(en), 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) sb_pop("a", q_a, a_oaddr, a_odata, a_oen);
      if (b_we) sb_pop("b", q_b, b_oaddr, b_odata, b_oen);
      if (c_we) sb_pop("c", q_c, c_oaddr, c_odata, c_oen);
      if (a_we || a_ien)
        chk("a_rw_excl", int'(a_we && a_ien), 0);
      if (a_ien) a_reads++;
      if (b_ien) begin
        b_reads++;
        chk("b_rd_in_win",
            int'(((b_iaddr % 25) / 5) < 4 && (b_iaddr % 5) < 4), 1);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},  int'(a_done), 0);
    chk({tag, "_valid"}, int'(a_valid), 0);
    chk({tag, "_ien"},   int'(a_ien), 0);
    chk({tag, "_iaddr"}, int'(a_iaddr), 0);
    chk({tag, "_oen"},   int'(a_oen), 0);
    chk({tag, "_we"},    int'(a_we), 0);
    chk({tag, "_oaddr"}, int'(a_oaddr), 0);
    chk({tag, "_odata"}, int'(a_odata), 0);
  endtask

  task automatic push_a();
    q_a.push_back(mk(0, 5));
    q_a.push_back(mk(1, 7));
    q_a.push_back(mk(2, 13));
    q_a.push_back(mk(3, 15));
  endtask

  // Raises start at a negedge; counts cycles after the sampling edge.
  task automatic run_a(input string name);
    int cyc;
    start_a = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (a_done) break;
      @(posedge clk);
      cyc++;
    end
    chk({name, "_latency"}, cyc, 45);
  endtask

  initial begin
    int cyc;
    int r0;
    int seen;
    for (int i = 0; i < 256; i++) begin
      mem_a[i]  = (i < 16) ? 8'(i) : 8'd200;
      mem_bc[i] = 8'd0;
    end
    for (int i = 0; i < 50; i++) begin
      int p, r, c;
      p = i % 25;
      r = p / 5;
      c = p % 5;
      if (r == 4 || c == 4) mem_bc[i] = 8'd100;
      else if (i < 25)      mem_bc[i] = 8'hFD;
      else begin
        case (p)
          0, 1, 5: mem_bc[i] = 8'h80;
          6:       mem_bc[i] = 8'h81;
          2:       mem_bc[i] = 8'd10;
          3:       mem_bc[i] = 8'hFB;
          7:       mem_bc[i] = 8'd3;
          8:       mem_bc[i] = 8'd9;
          10:      mem_bc[i] = 8'hFF;
          11:      mem_bc[i] = 8'hFE;
          15:      mem_bc[i] = 8'hFD;
          16:      mem_bc[i] = 8'hFC;
          12, 13:  mem_bc[i] = 8'h7F;
          17:      mem_bc[i] = 8'd0;
          default: mem_bc[i] = 8'd5;
        endcase
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    push_a();
    run_a("run1");
    chk("run1_valid", int'(a_valid), 1);

    r0 = a_reads;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("held_no_relaunch", a_reads - r0, 0);
    chk("held_done", int'(a_done), 1);
    chk("run1_q_empty", q_a.size(), 0);

    start_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("done_fall", int'(a_done), 0);

    push_a();
    run_a("run2");
    start_a = 1'b0;
    chk("run2_q_empty", q_a.size(), 0);

    for (int k = 0; k < 4; k++) begin
      q_b.push_back(mk(k, 0));
      q_c.push_back(mk(k, 8'hFD));
    end
    q_b.push_back(mk(4, 0));
    q_b.push_back(mk(5, 10));
    q_b.push_back(mk(6, 0));
    q_b.push_back(mk(7, 127));
    q_c.push_back(mk(4, 8'h81));
    q_c.push_back(mk(5, 10));
    q_c.push_back(mk(6, 8'hFF));
    q_c.push_back(mk(7, 127));

    start_bc = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (b_done) break;
      @(posedge clk);
      cyc++;
    end
    chk("bc_latency", cyc, 89);
    chk("c_done", int'(c_done), 1);
    start_bc = 1'b0;
    chk("b_reads", b_reads, 32);
    chk("b_q_empty", q_b.size(), 0);
    chk("c_q_empty", q_c.size(), 0);
    repeat (3) @(posedge clk);

    @(negedge clk);
    start_a = 1'b1;
    seen = 0;
    cyc = 0;
    while (seen < 3 && cyc < 100) begin
      @(negedge clk);
      if (a_ien) seen++;
      cyc++;
    end
    chk("mid_reads_seen", seen, 3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_idle_done", int'(a_done), 0);

    push_a();
    run_a("run3");
    start_a = 1'b0;
    chk("run3_q_empty", q_a.size(), 0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
